alu_ctrl_seq: RTL and testbench
===============================

# alu_ctrl_seq

Parametrised, handshaked ALU control unit for the multicycle datapath. It decodes the 2-bit ALUop from the main controller and the R-type funct field into a registered ALU control word. It adds shift and multiply encodings, flags illegal functs, and sequences multi-cycle operations (mult) with a busy countdown. It sits between the main control FSM and the ALU and replaces the purely combinational 3-bit ALU-control decoder.

## Interface

**Parameters**
- `CTRL_W`, default 4: control word width, ≥4. Codes are zero-extended above bit 3.
- `FUNCT_W`, default 6: funct field width, ≥6. Only `funct[5:0]` is decoded; upper bits must be 0, otherwise the funct is illegal.
- `MUL_CYCLES`, default 4: total latency of a multi-cycle op, ≥2.

**Ports** (clock and reset first)
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `flush` in 1: synchronous abort of any pending or in-flight op.
- `in_valid` in 1: request present.
- `in_ready` out 1: unit can accept a request.
- `alu_op` in 2: 00 add, 01 sub, 10 R-type (use funct), 11 or (ori).
- `funct` in `FUNCT_W`: R-type function field.
- `out_valid` out 1: `alu_ctrl`/`illegal` valid.
- `out_ready` in 1: consumer takes the result.
- `alu_ctrl` out `CTRL_W`: control word.
- `illegal` out 1: funct not recognised, qualified by `out_valid`.
- `mc_busy` out 1: multi-cycle op counting.

## Operation

**Encodings** (`alu_ctrl`, 4 LSBs)
- and 0000, or 0001, add 0010, sub 0110, slt 0111, nor 1100, sll 1000, srl 1001, mult 1010, illegal 1111.

**Funct map** (`alu_op` = 10)
- 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 100111 nor, 000000 sll, 000010 srl, 011000 mult.
- Any other funct: `alu_ctrl` = 1111 and `illegal` = 1.
- For `alu_op` ≠ 10, funct is ignored and `illegal` = 0.

**FSM states:** IDLE, BUSY, VALID.
- **IDLE:** `in_ready` = 1. On `in_valid` the decoded word and flag are captured.
  - mult goes to BUSY with `cnt` = `MUL_CYCLES`-2.
  - All other ops (including illegal) go to VALID.
- **BUSY:** `mc_busy` = 1, `in_ready` = 0, `out_valid` = 0. `cnt` decrements each cycle; when `cnt` = 0, go to VALID.
- **VALID:** `out_valid` = 1 and the outputs hold steady until `out_ready`.
  - On `out_ready`: if `in_valid` is also high, the new request is accepted the same cycle (`in_ready` = `out_ready` in VALID) and the FSM goes to BUSY or VALID as decoded. Otherwise go to IDLE.
- **flush:** overrides everything. Next state is IDLE, `in_ready` = 0 during the flush cycle, and a simultaneous `in_valid` is not accepted. The pending result is dropped.
- `cnt` width is `$clog2(MUL_CYCLES)`, minimum 1. `cnt` never wraps below 0.

## Timing

- **Reset values:** state IDLE, `out_valid` 0, `alu_ctrl` 0, `illegal` 0, `mc_busy` 0, `cnt` 0. `in_ready` is 1 after reset deasserts.
- Reset mid-BUSY or mid-VALID returns the unit to IDLE immediately (asynchronous), with no output glitch to `out_valid` = 1.
- **Single-cycle op** accepted at edge k: `out_valid` = 1 after edge k.
- **Mult** accepted at edge k: `mc_busy` = 1 from edge k to edge k+`MUL_CYCLES`-1; `out_valid` = 1 after edge k+`MUL_CYCLES`-1.
- **Throughput:** one single-cycle op per clock when `out_ready` is held high. Mult throughput is one per `MUL_CYCLES` clocks.
- All outputs are registered, except `in_ready`, which is combinational from state, `out_ready` and `flush`.

## Structure

- **Package `alu_ctrl_pkg`:** ALUop encodings, funct constants, ALU control code constants, and the state enum.
- **Sub-module `alu_ctrl_dec`:** purely combinational (`alu_op`, `funct`) → (`ctrl`, `illegal`, `is_multi`). The top holds the FSM, counter and output registers.

## Test plan

- **Reset/idle:** assert `rst` mid-run → all outputs 0 and `in_ready` 1 after release; sweep `alu_op` 00/01/11 → `alu_ctrl` 0010/0110/0001, one cycle latency.
- **R-type sweep:** all 9 legal functs with `alu_op` = 10, `out_ready` held 1 → back-to-back results, one per cycle, codes as mapped. Funct 001000 → `alu_ctrl` 1111 and `illegal` 1.
- **Mult with `MUL_CYCLES` = 4:** accept at edge 0 → `mc_busy` high for 3 cycles, `out_valid` after edge 3, `in_ready` low throughout BUSY.
- **Backpressure:** `out_ready` = 0 for 5 cycles after a sub result → `alu_ctrl` stays 0110 and `in_ready` stays 0. Then raise `out_ready` together with `in_valid` (add) → next cycle `alu_ctrl` = 0010.
- **Flush:** flush during BUSY, and flush with `in_valid` high in IDLE → next cycle IDLE, `out_valid` 0, no request accepted.
- **Parameters:** `CTRL_W` = 6, `FUNCT_W` = 8, `MUL_CYCLES` = 2 → zero-extended codes, a funct with upper bit set → illegal, and mult result after edge 1.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control unit.
//   - ALUop encodings from the main controller
//   - R-type funct values (low 6 bits)
//   - 4-bit ALU control codes (zero-extended to CTRL_W by the decoder)
//   - sequencer state enum
package alu_ctrl_pkg;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_RT  = 2'b10;
  localparam logic [1:0] ALUOP_OR  = 2'b11;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_MULT = 6'b011000;

  localparam logic [3:0] CODE_AND  = 4'b0000;
  localparam logic [3:0] CODE_OR   = 4'b0001;
  localparam logic [3:0] CODE_ADD  = 4'b0010;
  localparam logic [3:0] CODE_SUB  = 4'b0110;
  localparam logic [3:0] CODE_SLT  = 4'b0111;
  localparam logic [3:0] CODE_NOR  = 4'b1100;
  localparam logic [3:0] CODE_SLL  = 4'b1000;
  localparam logic [3:0] CODE_SRL  = 4'b1001;
  localparam logic [3:0] CODE_MULT = 4'b1010;
  localparam logic [3:0] CODE_ILL  = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_VALID = 2'd2
  } state_t;

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// Handshake bundle between the main controller (master) and the ALU control
// unit (slave).
//   in_valid/in_ready   request handshake, carries alu_op + funct
//   out_valid/out_ready result handshake, carries alu_ctrl + illegal
//   flush               synchronous abort from the controller
//   mc_busy             multi-cycle op in progress
interface alu_ctrl_seq_if #(
  parameter int CTRL_W  = 4,
  parameter int FUNCT_W = 6
);
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         alu_op;
  logic [FUNCT_W-1:0] funct;
  logic               out_valid;
  logic               out_ready;
  logic [CTRL_W-1:0]  alu_ctrl;
  logic               illegal;
  logic               mc_busy;
  logic               flush;

  modport master (
    output in_valid, alu_op, funct, out_ready, flush,
    input  in_ready, out_valid, alu_ctrl, illegal, mc_busy
  );

  modport slave (
    input  in_valid, alu_op, funct, out_ready, flush,
    output in_ready, out_valid, alu_ctrl, illegal, mc_busy
  );
endinterface

// File: rtl/alu_ctrl_dec.sv
// Combinational ALUop/funct decoder.
//   alu_op   in  2        ALUop from the main controller
//   funct    in  FUNCT_W  R-type function field
//   ctrl     out CTRL_W   control code, zero-extended from 4 bits
//   illegal  out 1        funct not recognised (R-type only)
//   is_multi out 1        op needs the multi-cycle sequence (mult)
module alu_ctrl_dec
  import alu_ctrl_pkg::*;
#(
  parameter int CTRL_W  = 4,
  parameter int FUNCT_W = 6
) (
  input  logic [1:0]         alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output logic [CTRL_W-1:0]  ctrl,
  output logic               illegal,
  output logic               is_multi
);

  logic [3:0] code;
  logic       upper_zero;

  // Any bit set above funct[5] makes the R-type funct unrecognisable.
  assign upper_zero = ((funct >> 6) == '0);

  always_comb begin
    code     = CODE_ILL;
    illegal  = 1'b0;
    is_multi = 1'b0;
    case (alu_op)
      ALUOP_ADD: code = CODE_ADD;
      ALUOP_SUB: code = CODE_SUB;
      ALUOP_OR:  code = CODE_OR;
      default: begin
        illegal = 1'b1;
        if (upper_zero) begin
          illegal = 1'b0;
          case (funct[5:0])
            FN_ADD:  code = CODE_ADD;
            FN_SUB:  code = CODE_SUB;
            FN_AND:  code = CODE_AND;
            FN_OR:   code = CODE_OR;
            FN_SLT:  code = CODE_SLT;
            FN_NOR:  code = CODE_NOR;
            FN_SLL:  code = CODE_SLL;
            FN_SRL:  code = CODE_SRL;
            FN_MULT: begin
              code     = CODE_MULT;
              is_multi = 1'b1;
            end
            default: begin
              code    = CODE_ILL;
              illegal = 1'b1;
            end
          endcase
        end
      end
    endcase
  end

  assign ctrl = CTRL_W'(code);

endmodule

// File: rtl/alu_ctrl_seq.sv
// Handshaked ALU control unit: decodes ALUop/funct into a registered control
// word and sequences multi-cycle ops (mult) with a busy countdown.
//   clk  in  rising-edge clock
//   rst  in  asynchronous active-high reset
//   bus  slave side of alu_ctrl_seq_if (request, result, flush, mc_busy)
//
// state   | meaning
// S_IDLE  | no result held, ready for a request
// S_BUSY  | multi-cycle op counting down, mc_busy high
// S_VALID | result presented, held until out_ready
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int CTRL_W     = 4,
  parameter int FUNCT_W    = 6,
  parameter int MUL_CYCLES = 4
) (
  input logic          clk,
  input logic          rst,
  alu_ctrl_seq_if.slave bus
);

  localparam int CNT_W = ($clog2(MUL_CYCLES) < 1) ? 1 : $clog2(MUL_CYCLES);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               out_valid_q;
  logic [CTRL_W-1:0]  alu_ctrl_q;
  logic               illegal_q;
  logic               mc_busy_q;

  logic [CTRL_W-1:0]  dec_ctrl;
  logic               dec_illegal;
  logic               dec_multi;
  logic               in_ready_c;
  logic               accept;

  alu_ctrl_dec #(
    .CTRL_W  (CTRL_W),
    .FUNCT_W (FUNCT_W)
  ) u_dec (
    .alu_op   (bus.alu_op),
    .funct    (bus.funct),
    .ctrl     (dec_ctrl),
    .illegal  (dec_illegal),
    .is_multi (dec_multi)
  );

  // In VALID a new request rides on the same edge the current result leaves.
  assign in_ready_c = !bus.flush &&
                      ((state == S_IDLE) || ((state == S_VALID) && bus.out_ready));
  assign accept     = bus.in_valid && in_ready_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      alu_ctrl_q  <= '0;
      illegal_q   <= 1'b0;
      mc_busy_q   <= 1'b0;
    end else if (bus.flush) begin
      state       <= S_IDLE;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      mc_busy_q   <= 1'b0;
    end else begin
      case (state)
        S_BUSY: begin
          if (cnt == '0) begin
            state       <= S_VALID;
            out_valid_q <= 1'b1;
            mc_busy_q   <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          if (accept) begin
            alu_ctrl_q <= dec_ctrl;
            illegal_q  <= dec_illegal;
            if (dec_multi) begin
              // Accept edge plus MUL_CYCLES-1 counting edges.
              state       <= S_BUSY;
              cnt         <= CNT_W'(MUL_CYCLES - 2);
              out_valid_q <= 1'b0;
              mc_busy_q   <= 1'b1;
            end else begin
              state       <= S_VALID;
              out_valid_q <= 1'b1;
              mc_busy_q   <= 1'b0;
            end
          end else if ((state == S_VALID) && bus.out_ready) begin
            state       <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.alu_ctrl  = alu_ctrl_q;
  assign bus.illegal   = illegal_q;
  assign bus.mc_busy   = mc_busy_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq: default-parameter instance (a) and a
// CTRL_W=6 / FUNCT_W=8 / MUL_CYCLES=2 instance (b).
module tb_alu_ctrl_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  alu_ctrl_seq_if #(.CTRL_W(4), .FUNCT_W(6)) ia ();
  alu_ctrl_seq_if #(.CTRL_W(6), .FUNCT_W(8)) ib ();

  alu_ctrl_seq #(.CTRL_W(4), .FUNCT_W(6), .MUL_CYCLES(4)) u_a (
    .clk (clk),
    .rst (rst),
    .bus (ia.slave)
  );

  alu_ctrl_seq #(.CTRL_W(6), .FUNCT_W(8), .MUL_CYCLES(2)) u_b (
    .clk (clk),
    .rst (rst),
    .bus (ib.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [5:0] fn_tab [8];
  logic [3:0] cd_tab [8];

  initial begin
    fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
               6'b101010, 6'b100111, 6'b000000, 6'b000010};
    cd_tab = '{4'b0010, 4'b0110, 4'b0000, 4'b0001,
               4'b0111, 4'b1100, 4'b1000, 4'b1001};

    ia.in_valid = 0; ia.alu_op = 2'b00; ia.funct = '0; ia.out_ready = 0; ia.flush = 0;
    ib.in_valid = 0; ib.alu_op = 2'b00; ib.funct = '0; ib.out_ready = 0; ib.flush = 0;

    // Reset values
    tick(); tick();
    chk("rst_out_valid", ia.out_valid, 0);
    chk("rst_alu_ctrl",  ia.alu_ctrl,  0);
    chk("rst_illegal",   ia.illegal,   0);
    chk("rst_mc_busy",   ia.mc_busy,   0);
    chk("rst_b_ctrl",    ib.alu_ctrl,  0);
    rst = 0;
    #1;
    chk("rst_in_ready", ia.in_ready, 1);

    // Non-R-type sweep, back to back, funct ignored
    ia.out_ready = 1;
    ia.in_valid  = 1;
    ia.funct     = 6'b001000;
    ia.alu_op    = 2'b00; tick();
    chk("op00_valid", ia.out_valid, 1);
    chk("op00_ctrl",  ia.alu_ctrl,  4'b0010);
    ia.alu_op    = 2'b01; tick();
    chk("op01_ctrl",  ia.alu_ctrl,  4'b0110);
    ia.alu_op    = 2'b11; tick();
    chk("op11_ctrl",  ia.alu_ctrl,  4'b0001);
    chk("op11_ill",   ia.illegal,   0);

    // R-type sweep, one result per cycle
    ia.alu_op = 2'b10;
    for (int i = 0; i < 8; i++) begin
      ia.funct = fn_tab[i];
      tick();
      chk($sformatf("rt_ctrl_%0d", i), ia.alu_ctrl, cd_tab[i]);
      chk($sformatf("rt_valid_%0d", i), ia.out_valid, 1);
      chk($sformatf("rt_ill_%0d", i), ia.illegal, 0);
    end
    ia.funct = 6'b001000; tick();
    chk("rt_bad_ctrl", ia.alu_ctrl, 4'b1111);
    chk("rt_bad_ill",  ia.illegal,  1);
    ia.in_valid = 0; tick();
    chk("drain_valid", ia.out_valid, 0);
    chk("idle_ready",  ia.in_ready,  1);

    // Mult, MUL_CYCLES=4: busy after edges 0..2, result after edge 3
    ia.in_valid = 1; ia.alu_op = 2'b10; ia.funct = 6'b011000;
    tick();
    ia.in_valid = 0;
    chk("mul_e0_busy",  ia.mc_busy,   1);
    chk("mul_e0_valid", ia.out_valid, 0);
    chk("mul_e0_ready", ia.in_ready,  0);
    tick();
    chk("mul_e1_busy",  ia.mc_busy,   1);
    chk("mul_e1_ready", ia.in_ready,  0);
    tick();
    chk("mul_e2_busy",  ia.mc_busy,   1);
    chk("mul_e2_valid", ia.out_valid, 0);
    tick();
    chk("mul_e3_busy",  ia.mc_busy,   0);
    chk("mul_e3_valid", ia.out_valid, 1);
    chk("mul_e3_ctrl",  ia.alu_ctrl,  4'b1010);
    tick();
    chk("mul_drain", ia.out_valid, 0);

    // Backpressure on a sub result
    ia.out_ready = 0;
    ia.in_valid = 1; ia.alu_op = 2'b01; tick();
    chk("bp_first", ia.alu_ctrl, 4'b0110);
    ia.alu_op = 2'b00;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp_hold_%0d", i),  ia.alu_ctrl,  4'b0110);
      chk($sformatf("bp_valid_%0d", i), ia.out_valid, 1);
      chk($sformatf("bp_ready_%0d", i), ia.in_ready,  0);
    end
    ia.out_ready = 1; #1;
    chk("bp_release_ready", ia.in_ready, 1);
    tick();
    chk("bp_next_ctrl",  ia.alu_ctrl,  4'b0010);
    chk("bp_next_valid", ia.out_valid, 1);
    ia.in_valid = 0; tick();
    chk("bp_drain", ia.out_valid, 0);

    // Flush during BUSY
    ia.in_valid = 1; ia.alu_op = 2'b10; ia.funct = 6'b011000; tick();
    ia.in_valid = 0; tick();
    ia.flush = 1; #1;
    chk("fl_busy_ready", ia.in_ready, 0);
    tick();
    ia.flush = 0; #1;
    chk("fl_busy_valid", ia.out_valid, 0);
    chk("fl_busy_mc",    ia.mc_busy,   0);
    chk("fl_busy_idle",  ia.in_ready,  1);
    tick(); tick(); tick();
    chk("fl_busy_late", ia.out_valid, 0);

    // Flush with in_valid in IDLE: nothing accepted
    ia.in_valid = 1; ia.alu_op = 2'b01; ia.flush = 1; #1;
    chk("fl_idle_ready", ia.in_ready, 0);
    tick();
    chk("fl_idle_valid", ia.out_valid, 0);
    chk("fl_idle_ctrl",  ia.alu_ctrl,  4'b1010);
    ia.flush = 0; ia.in_valid = 0; tick();
    chk("fl_idle_after", ia.out_valid, 0);

    // Asynchronous reset mid-VALID
    ia.out_ready = 0;
    ia.in_valid = 1; ia.alu_op = 2'b01; tick();
    ia.in_valid = 0;
    chk("rv_pre", ia.out_valid, 1);
    #2 rst = 1; #1;
    chk("rv_valid", ia.out_valid, 0);
    chk("rv_ctrl",  ia.alu_ctrl,  0);
    rst = 0; #1;
    chk("rv_ready", ia.in_ready, 1);

    // Asynchronous reset mid-BUSY
    ia.in_valid = 1; ia.alu_op = 2'b10; ia.funct = 6'b011000; tick();
    ia.in_valid = 0;
    #2 rst = 1; #1;
    chk("rb_busy",  ia.mc_busy,   0);
    chk("rb_valid", ia.out_valid, 0);
    rst = 0; #1;
    chk("rb_ready", ia.in_ready, 1);
    tick(); tick(); tick(); tick();
    chk("rb_late", ia.out_valid, 0);

    // Parameter instance: CTRL_W=6, FUNCT_W=8, MUL_CYCLES=2
    ib.out_ready = 1;
    ib.in_valid = 1; ib.alu_op = 2'b10; ib.funct = 8'h22; tick();
    chk("p_sub_ctrl", ib.alu_ctrl, 6'b000110);
    chk("p_sub_ill",  ib.illegal,  0);
    ib.funct = 8'hA0; tick();
    chk("p_up_ctrl", ib.alu_ctrl, 6'b001111);
    chk("p_up_ill",  ib.illegal,  1);
    ib.alu_op = 2'b00; ib.funct = 8'hFF; tick();
    chk("p_add_ctrl", ib.alu_ctrl, 6'b000010);
    chk("p_add_ill",  ib.illegal,  0);
    ib.alu_op = 2'b10; ib.funct = 8'h18; tick();
    ib.in_valid = 0;
    chk("p_mul_e0_busy",  ib.mc_busy,   1);
    chk("p_mul_e0_valid", ib.out_valid, 0);
    tick();
    chk("p_mul_e1_busy",  ib.mc_busy,   0);
    chk("p_mul_e1_valid", ib.out_valid, 1);
    chk("p_mul_e1_ctrl",  ib.alu_ctrl,  6'b001010);
    tick();
    chk("p_drain", ib.out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
